i2s_mic_rx: RTL and testbench

- Upstream front end of the audio path. Generates the I2S bit clock SCK from the 27 MHz system clock.
- Samples the microphone SD/WS pins and frames one channel's MSB-first words, with the standard I2S 1-bit delay.
- Delivers signed samples through a small FIFO with a valid/ready handshake to the STFT/processing stage.
- Reports overflow and framing errors as sticky flags.

---
 rtl/i2s_mic_rx_pkg.sv | 22 ++
 rtl/i2s_mic_rx_sample_fifo.sv | 53 +++++
 rtl/i2s_mic_rx.sv | 150 +++++++++++++++
 tb/tb_i2s_mic_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_mic_rx_pkg.sv
// Shared types and helpers for the I2S microphone receiver.
package i2s_pkg;

  // Framer states.
  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    SHIFT,
    SKIP
  } state_t;

  // WS level that selects each channel.
  localparam logic CHANNEL_LEFT  = 1'b0;
  localparam logic CHANNEL_RIGHT = 1'b1;

  // Counter width needed to hold 0..n-1. Used to size the SCK divider,
  // the bit counter and the FIFO pointers.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_mic_rx_sample_fifo.sv
// Synchronous first-word-fall-through FIFO for captured samples.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = cnt_width(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: generates SCK, frames one channel's MSB-first
// words (1-bit delay after WS edge) and queues them for the next stage.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int SCK_DIV    = 8,
  parameter int CHANNEL    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  SD,
  input  logic                  WS,
  output logic                  SCK,
  output logic [WORD_WIDTH-1:0] sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int   DIV_W   = cnt_width(SCK_DIV);
  localparam int   BIT_W   = cnt_width(WORD_WIDTH);
  localparam int   HALF    = SCK_DIV / 2;
  localparam logic CHAN_WS = (CHANNEL != 0) ? CHANNEL_RIGHT : CHANNEL_LEFT;

  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [1:0]            sd_sync, ws_sync;
  logic                  sd_s, ws_s, ws_prev, ws_edge, strobe;
  state_t                state, state_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-1:0] shreg;
  logic                  shift_en, word_done, word_err;
  logic                  push_q, pop, fifo_full, fifo_empty;

  assign div_nxt = (div_cnt == DIV_W'(SCK_DIV-1)) ? '0 : div_cnt + DIV_W'(1);
  // Last clk of SCK high: data from the mic has been stable since the rise.
  assign strobe  = enable && (div_cnt == DIV_W'(HALF-1));
  assign sd_s    = sd_sync[1];
  assign ws_s    = ws_sync[1];
  assign ws_edge = (ws_s != ws_prev);

  // SCK divider; SCK is registered from the next count so it rises at the wrap.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      div_cnt <= '0;
      SCK     <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      SCK     <= (div_nxt < DIV_W'(HALF));
    end
  end

  // Two-flop synchronisers for the asynchronous mic pins, plus captured WS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sd_sync <= '0;
      ws_sync <= '0;
      ws_prev <= 1'b0;
    end else begin
      sd_sync <= {sd_sync[0], SD};
      ws_sync <= {ws_sync[0], WS};
      if (strobe) ws_prev <= ws_s;
    end
  end

  // Framer state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Framer next state; every WS edge resynchronises to the slot it opens.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    word_done = 1'b0;
    word_err  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE: state_nxt = HUNT;
        HUNT, SKIP: begin
          if (ws_edge) state_nxt = (ws_s == CHAN_WS) ? SHIFT : SKIP;
        end
        SHIFT: begin
          if (ws_edge) begin
            word_err  = 1'b1;
            state_nxt = (ws_s == CHAN_WS) ? SHIFT : SKIP;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == BIT_W'(WORD_WIDTH-1)) begin
              word_done = 1'b1;
              state_nxt = SKIP;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shift register and bit counter; counter restarts whenever a word is not in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) begin
        shreg   <= {shreg[WORD_WIDTH-2:0], sd_s};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (state_nxt != SHIFT || word_err) bit_cnt <= '0;
    end
  end

  // Push one clk after the final bit (shreg then holds the whole word); sticky flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      push_q    <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_q <= word_done;
      if (push_q && fifo_full && !pop) overflow <= 1'b1;
      if (word_err) frame_err <= 1'b1;
    end
  end

  assign sample_valid = !fifo_empty;
  assign pop          = sample_valid && sample_ready;

  sample_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (sample_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench: a mic model driven off SCK falls feeds a left- and a
// right-channel receiver sharing the same SD/WS stream.
module tb_i2s_mic_rx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         SD = 1'b0;
  logic         WS = 1'b1;
  logic         r0 = 1'b0, r1 = 1'b0;
  logic         sck0, sck1, v0, v1, ov0, ov1, fe0, fe1;
  logic [W-1:0] d0, d1;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise0 = -1;
  int   left_lsb_cyc = 0;
  logic v0_d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (v0 && !v0_d) rise0 = cyc;
    v0_d = v0;
  end

  i2s_mic_rx #(.WORD_WIDTH(W), .SCK_DIV(8), .CHANNEL(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .SD(SD), .WS(WS), .SCK(sck0),
    .sample_data(d0), .sample_valid(v0), .sample_ready(r0),
    .overflow(ov0), .frame_err(fe0)
  );

  i2s_mic_rx #(.WORD_WIDTH(W), .SCK_DIV(8), .CHANNEL(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .SD(SD), .WS(WS), .SCK(sck1),
    .sample_data(d1), .sample_valid(v1), .sample_ready(r1),
    .overflow(ov1), .frame_err(fe1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an SCK falling edge, seen #1 after the clk edge.
  task automatic wait_fall();
    logic prev;
    bit   ok;
    prev = sck0;
    ok   = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (prev && !sck0) ok = 1'b1;
      prev = sck0;
    end
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL sck_fall_timeout observed=no_fall expected=fall");
    end
  endtask

  // One slot of len SCK periods: period 0 carries the previous LSB (0),
  // periods 1..16 the word MSB first, the rest padding.
  task automatic send_slot(input logic ws, input logic [15:0] word, input int len);
    for (int p = 0; p < len; p++) begin
      wait_fall();
      WS = ws;
      SD = (p >= 1 && p <= 16) ? word[16-p] : 1'b0;
      if (p == 16 && ws == 1'b0) left_lsb_cyc = cyc;
    end
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, 32'(v0), 32'd1);
    chk({tag, "_data"}, 32'(d0), 32'(exp));
    r0 = 1'b1;
    tick(1);
    r0 = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int          hi;
    pat = '0;

    // Reset state
    tick(3);
    chk("rst_sck", 32'(sck0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_overflow", 32'(ov0), 0);
    chk("rst_frame_err", 32'(fe0), 0);
    reset = 1'b1;
    tick(2);
    chk("disabled_sck", 32'(sck0), 0);

    // SCK waveform once enabled: 4 high / 4 low
    enable = 1'b1;
    tick(3);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      pat = {pat[14:0], sck0};
    end
    chk("sck_pattern", 32'(pat), 32'h0F0F);
    chk("no_word_yet", 32'(v0), 0);

    // One stereo frame: left 0xA5C3, right 0x1234
    send_slot(1'b0, 16'hA5C3, 32);
    send_slot(1'b1, 16'h1234, 32);
    tick(12);
    chk("valid_latency", 32'(rise0), 32'(left_lsb_cyc + 9));
    chk("ch1_valid", 32'(v1), 1);
    chk("ch1_data", 32'(d1), 32'h1234);
    pop_chk("left_word", 16'hA5C3);
    chk("right_not_captured", 32'(v0), 0);
    r1 = 1'b1;
    tick(1);
    chk("ch1_single_word", 32'(v1), 0);

    // Overflow: five left words with the consumer stalled
    for (int k = 1; k <= 5; k++) begin
      send_slot(1'b0, 16'(k), 32);
      send_slot(1'b1, 16'h0000, 32);
      if (k == 4) begin
        tick(12);
        chk("full_no_overflow", 32'(ov0), 0);
        chk("full_head", 32'(d0), 1);
      end
    end
    tick(12);
    chk("overflow_set", 32'(ov0), 1);
    pop_chk("drain1", 16'd1);
    pop_chk("drain2", 16'd2);
    pop_chk("drain3", 16'd3);
    pop_chk("drain4", 16'd4);
    chk("drained_valid", 32'(v0), 0);
    chk("overflow_sticky", 32'(ov0), 1);

    // Framing error: WS toggles after 10 bits of the left slot
    chk("no_frame_err_yet", 32'(fe0), 0);
    send_slot(1'b0, 16'h0BAD, 11);
    send_slot(1'b1, 16'h0000, 32);
    tick(12);
    chk("frame_err_set", 32'(fe0), 1);
    chk("short_word_dropped", 32'(v0), 0);
    send_slot(1'b0, 16'h7FFF, 32);
    send_slot(1'b1, 16'h0000, 32);
    tick(12);
    pop_chk("after_frame_err", 16'h7FFF);
    chk("after_frame_err_empty", 32'(v0), 0);

    // Enable dropped mid-word, then resumed
    send_slot(1'b0, 16'h5555, 7);
    enable = 1'b0;
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (sck0) hi++;
    end
    chk("sck_low_disabled", 32'(hi), 0);
    enable = 1'b1;
    send_slot(1'b1, 16'h0000, 32);
    tick(2);
    chk("partial_discarded", 32'(v0), 0);
    send_slot(1'b0, 16'h8000, 32);
    send_slot(1'b1, 16'h0000, 32);
    tick(12);
    pop_chk("resync_word", 16'h8000);
    chk("resync_single", 32'(v0), 0);
    chk("frame_err_sticky", 32'(fe0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
